dual_rail_receiver: RTL

Synthesizable receiving end of the dual-rail link: samples a WIDTH-bit dual-rail bus (two-phase "TP" or four-phase "FP"), detects codeword completion, decodes the data into a clocked valid/ready stream and returns the link acknowledge. It sits at the boundary between an asynchronous dual-rail channel and the synchronous core. It pairs with the dual-rail bus transmitters in the same environment.

---
 rtl/dual_rail_receiver.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dual_rail_receiver.sv
// dual_rail_receiver
//   Receiving end of an asynchronous dual-rail link. Every rail is run through
//   a synchronizer, the synchronized bus is checked for codeword completion,
//   and each complete word is decoded into a one-entry valid/ready buffer.
//   The link acknowledge is then returned to the transmitter.
//   ENC selects the protocol:
//     "TP" two-phase: each bit toggles exactly one rail per word.
//     "FP" four-phase: each bit raises one rail, then all rails return to zero.
//
// Ports
//   clk        core clock
//   rst        asynchronous, active-high reset
//   in         dual-rail bus, in[i][1] = true rail, in[i][0] = false rail
//   ack        link acknowledge to the transmitter
//   out_data   decoded word
//   out_valid  out_data holds a word that has not been consumed yet
//   out_ready  consumer takes the word when out_valid & out_ready
//   err        sticky protocol error
//
// Four-phase FSM
//   state       | meaning
//   ------------+---------------------------------------------------------
//   S_IDLE      | ack low, waiting for a complete codeword
//   S_HOLD      | complete codeword seen, output buffer busy, not yet taken
//   S_NULL_WAIT | word taken, ack high, waiting for every rail to return low
//   S_ERR       | protocol violation; frozen until reset
module dual_rail_receiver #(
  parameter string ENC         = "TP",
  parameter int    WIDTH       = 1,
  parameter int    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0][1:0] in,
  output logic                  ack,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err
);

  if (!(ENC == "TP" || ENC == "FP") || SYNC_STAGES < 2) begin : g_param_check
    $error("dual_rail_receiver: ENC must be \"TP\" or \"FP\" and SYNC_STAGES >= 2");
  end

  localparam bit IS_FP = (ENC == "FP");

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_NULL_WAIT,
    S_ERR
  } state_t;

  state_t                                 state_q, state_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] sync_q;
  logic [WIDTH-1:0][1:0]                  s;
  logic [WIDTH-1:0][1:0]                  ref_q, ref_d;
  logic [WIDTH-1:0]                       data_q, data_d;
  logic                                   ack_q, ack_d;
  logic                                   valid_q, valid_d;
  logic                                   err_q, err_d;

  logic [WIDTH-1:0] rail_t, rail_f, tog_t, tog_f;
  logic             free, load, err_set;
  logic             fp_complete, fp_illegal, fp_null;
  logic             tp_complete, tp_illegal;

  // The last synchronizer stage is the only view of the bus the logic uses.
  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    rail_t = '0;
    rail_f = '0;
    tog_t  = '0;
    tog_f  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rail_t[i] = s[i][1];
      rail_f[i] = s[i][0];
      tog_t[i]  = s[i][1] ^ ref_q[i][1];
      tog_f[i]  = s[i][0] ^ ref_q[i][0];
    end
  end

  // Four-phase: a bit is complete when exactly one rail is high.
  assign fp_complete = &(rail_t ^ rail_f);
  assign fp_illegal  = |(rail_t & rail_f);
  assign fp_null     = ~|{rail_t, rail_f};

  // Two-phase: a bit is complete when exactly one rail differs from the
  // last accepted rail state.
  assign tp_complete = &(tog_t ^ tog_f);
  assign tp_illegal  = |(tog_t & tog_f);

  assign free = !valid_q || out_ready;

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    data_d  = data_q;
    ack_d   = ack_q;
    load    = 1'b0;
    err_set = 1'b0;

    if (IS_FP) begin
      case (state_q)
        S_IDLE: begin
          if (fp_illegal) begin
            err_set = 1'b1;
            state_d = S_ERR;
          end else if (fp_complete) begin
            if (free) begin
              load    = 1'b1;
              data_d  = rail_t;
              ack_d   = 1'b1;
              state_d = S_NULL_WAIT;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // A held word that stops being complete can only be a protocol
          // violation: the transmitter may not withdraw data before ack.
          if (fp_illegal || !fp_complete) begin
            err_set = 1'b1;
            state_d = S_ERR;
          end else if (free) begin
            load    = 1'b1;
            data_d  = rail_t;
            ack_d   = 1'b1;
            state_d = S_NULL_WAIT;
          end
        end
        S_NULL_WAIT: begin
          if (fp_illegal) begin
            err_set = 1'b1;
            state_d = S_ERR;
          end else if (fp_null) begin
            ack_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_ERR;
        end
      endcase
    end else begin
      if (!err_q) begin
        if (tp_illegal) begin
          err_set = 1'b1;
        end else if (tp_complete && free) begin
          load   = 1'b1;
          data_d = tog_t;
          ref_d  = s;
          ack_d  = !ack_q;
        end
      end
    end

    // A load in the same cycle as a consume keeps the buffer full.
    valid_d = load || (valid_q && !out_ready);
    err_d   = err_q || err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= S_IDLE;
      ref_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      state_q <= state_d;
      ref_q   <= ref_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ack       = ack_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign err       = err_q;

endmodule
